// File: rtl/vscale_md_unit.sv
// vscale_md_unit: iterative RV32M multiply/divide unit beside the DX-stage ALU.
// Ports: clk/reset (async, active-high); req_valid/req_ready/req_op/req_in_1/req_in_2
// request port; kill aborts; resp_valid/resp_ready/resp_result response port.
// Latency: accept, 32 compute cycles, then DONE until resp_ready; req_ready only in IDLE.
module vscale_md_unit #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [XPR_LEN-1:0] req_in_1,
  input  logic [XPR_LEN-1:0] req_in_2,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [XPR_LEN-1:0] resp_result
);
  localparam int W = XPR_LEN;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_a_q, neg_a_d;
  logic           neg_b_q, neg_b_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  // Multiply: {partial high, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  logic [2*W-1:0] acc_q, acc_d;

  logic           sign_a, sign_b, in_neg_a, in_neg_b;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     mul_sum, div_rs;
  logic           div_ge;
  logic [2*W-1:0] prod_signed;
  logic [W-1:0]   quo_signed, rem_signed;

  // Operand signedness from funct3: MULH, DIV, REM signed both; MULHSU signed a only.
  always_comb begin
    sign_a   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    sign_b   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    in_neg_a = sign_a && req_in_1[W-1];
    in_neg_b = sign_b && req_in_2[W-1];
    mag_a    = in_neg_a ? (~req_in_1 + 1'b1) : req_in_1;
    mag_b    = in_neg_b ? (~req_in_2 + 1'b1) : req_in_2;
  end

  // One iteration of each algorithm, computed from the current registers.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rs  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge  = (div_rs >= {1'b0, b_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
          op_d    = req_op;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          a_d     = mag_a;
          b_d     = mag_b;
          acc_d   = req_op[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
        end
      end
      S_COMPUTE: begin
        if (op_q[2]) begin
          // Remainder is always < divisor, so the low W bits of the difference suffice.
          acc_d = {(div_ge ? (div_rs[W-1:0] - b_q) : div_rs[W-1:0]), acc_q[W-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins; whatever the datapath loaded this cycle is never reported.
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);

  // Result is decoded purely from registers, so it is stable while DONE is held.
  // A zero divisor keeps the all-ones quotient and the untouched dividend as remainder.
  always_comb begin
    prod_signed = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
    quo_signed  = ((neg_a_q ^ neg_b_q) && (b_q != '0)) ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
    rem_signed  = neg_a_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    case (op_q)
      3'd0:                resp_result = prod_signed[W-1:0];
      3'd1, 3'd2, 3'd3:    resp_result = prod_signed[2*W-1:W];
      3'd4, 3'd5:          resp_result = quo_signed;
      default:             resp_result = rem_signed;
    endcase
  end
endmodule

// File: tb/tb_vscale_md_unit.sv
module tb_vscale_md_unit;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, kill, resp_valid, resp_ready;
  logic [2:0]  req_op;
  logic [31:0] req_in_1, req_in_2, resp_result;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  vscale_md_unit #(.XPR_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_in_1(req_in_1), .req_in_2(req_in_2), .kill(kill),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural RV32M semantics computed with wide signed arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the accept edge.
  // Inputs are then scrambled: the unit must have sampled them at accept only.
  task automatic accept(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_in_1 = a; req_in_2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_in_1  = $urandom;
    req_in_2  = $urandom;
  endtask

  // lat = rising edges after the accept edge until resp_valid is seen (expected 32).
  task automatic wait_resp(output logic [31:0] res, output int lat, output bit rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!resp_valid && lat < 40) begin
      rdy_seen |= req_ready;
      @(negedge clk);
      lat++;
    end
    res = resp_result;
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    bit rdy_seen;
    accept(op, a, b);
    wait_resp(res, lat, rdy_seen);
    check(name, res, exp);
    check({name, " latency"}, 32'(lat), 32'd32);
    check({name, " req_ready during op"}, 32'(rdy_seen), 32'd0);
    @(negedge clk);
    check({name, " idle after handshake"}, {30'd0, req_ready, resp_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] res, held, ra, rb;
    logic [2:0]  rop;
    int lat;
    bit rdy_seen, seen;

    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_in_1 = '0; req_in_2 = '0;
    kill = 1'b0; resp_ready = 1'b1;
    #12;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_result", resp_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    add("MUL 7x6",      3'd0, 32'd7,          32'd6,          32'd42);
    add("MULH -1x-1",   3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000);
    add("MULHU ffxff",  3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE);
    add("MULHSU ffxff", 3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF);
    add("MUL ffxff",    3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001);
    add("MULH min*min", 3'd1, 32'h80000000,   32'h80000000,   32'h40000000);
    add("DIV -7/2",     3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD);
    add("REM -7/2",     3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF);
    add("DIVU 7/2",     3'd5, 32'd7,          32'd2,          32'd3);
    add("REMU 7/2",     3'd7, 32'd7,          32'd2,          32'd1);
    add("DIV 5/0",      3'd4, 32'd5,          32'd0,          32'hFFFFFFFF);
    add("REM 5/0",      3'd6, 32'd5,          32'd0,          32'd5);
    add("DIVU 5/0",     3'd5, 32'd5,          32'd0,          32'hFFFFFFFF);
    add("REM -5/0",     3'd6, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB);
    add("DIV ovf",      3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000);
    add("REM ovf",      3'd6, 32'h80000000,   32'hFFFFFFFF,   32'd0);
    foreach (vecs[i]) run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Response held off for 5 cycles: result and valid must stay put.
    resp_ready = 1'b0;
    accept(3'd0, 32'd1234, 32'd5678);
    wait_resp(held, lat, rdy_seen);
    check("hold first result", held, 32'd7006652);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold resp_valid", 32'(resp_valid), 32'd1);
      check("hold resp_result", resp_result, held);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("hold released idle", {30'd0, req_ready, resp_valid}, 32'b10);

    // kill in IDLE blocks the accept.
    req_valid = 1'b1; req_op = 3'd0; req_in_1 = 32'd2; req_in_2 = 32'd2; kill = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; kill = 1'b0;
    check("kill idle no accept", 32'(req_ready), 32'd1);

    // kill at compute cycle 10.
    accept(3'd0, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill returns idle", {30'd0, req_ready, resp_valid}, 32'b10);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen |= resp_valid;
      @(negedge clk);
    end
    check("kill no response", 32'(seen), 32'd0);
    run_check("MUL 3x3 after kill", 3'd0, 32'd3, 32'd3, 32'd9);

    // Asynchronous reset at compute cycle 20.
    accept(3'd4, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset req_ready", 32'(req_ready), 32'd1);
    check("async reset resp_valid", 32'(resp_valid), 32'd0);
    check("async reset resp_result", resp_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_check("DIV 100/7 after reset", 3'd4, 32'd100, 32'd7, 32'd14);

    // Randomized operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = 32'($urandom_range(1, 300));
        default: ;
      endcase
      run_check("random", rop, ra, rb, ref_md(rop, ra, rb));
    end

    res = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
